// File: rtl/count_uart_pkg.sv
// ----------------------------------------------------------------
// count_uart_pkg : shared types and constants for count_uart_tx
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic TX_IDLE         = 1'b1;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

endpackage

`default_nettype wire

// File: rtl/snap_fifo.sv
// ----------------------------------------------------------------
// snap_fifo : synchronous FIFO with enable gate and occupancy-derived flags
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module snap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign rd_en = ena & pop & ~empty;
  assign wr_en = ena & push & (~full | rd_en);

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/count_uart_tx.sv
// ----------------------------------------------------------------
// count_uart_tx : snapshots the counter into a FIFO and sends each entry as 8N1
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] data_in,
  input  logic              capture,
  input  logic              clear_ovf,
  output logic              tx,
  output logic              busy,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(FRAME_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_DATA_BITS - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              overflow_q;
  logic              pop;
  logic              baud_end;
  logic [DATA_W-1:0] fifo_rdata;

  snap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_snap_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .push  (capture),
    .pop   (pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        tx_d   = TX_IDLE;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
          baud_d  = '0;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Chain straight into the next frame so queued entries go out gap-free.
        if (baud_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
            tx_d    = START_BIT;
          end else begin
            state_d = IDLE;
            tx_d    = TX_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = TX_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= TX_IDLE;
      busy_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // A dropped capture takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (ena) begin
      if (capture && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end else if (clear_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Downstream consumer of the 8-bit counter value. Snapshots the count on a capture strobe into a small FIFO, then serialises each entry as an 8N1 UART frame on a single output pin. Lets the board report counter values over one uo_out bit without a logic analyser. Sits between the counter register and the top-level output mux.

Parameters:
CLK_DIV, 16, clk cycles per UART bit; legal values ≥2
FIFO_DEPTH, 4, snapshot FIFO entries; power of 2, ≥2
DATA_W, 8, width of captured value and frame payload

Ports:
clk  input  1  clock
rst_n  input  1  reset
ena  input  1  harness enable; low freezes all state
data_in  input  DATA_W  counter value to snapshot
capture  input  1  level-sampled snapshot request; one push per high cycle
clear_ovf  input  1  synchronous clear of the overflow flag
tx  output  1  UART serial out; idle high
busy  output  1  high while a frame is being shifted (START/DATA/STOP)
fifo_empty  output  1  FIFO holds no entries
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
overflow  output  1  sticky; a capture was dropped because the FIFO was full

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values: tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- ena=0: FIFO, FSM, baud counter and overflow all hold; tx holds its current level; capture and clear_ovf are ignored.
- Push: when ena=1, capture=1 and the FIFO is not full, data_in is written at the edge. If the FIFO is full, data is dropped and overflow is set.
- Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted and overflow stays unchanged.
- overflow: a set and clear_ovf in the same cycle leave overflow=1 (set wins).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, enter START, reset the baud counter.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: tx=shift[0]; shift right every CLK_DIV cycles; 8 bits, LSB first.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Latency: with FIFO empty and FSM in IDLE, a capture sampled at edge k makes fifo_empty=0 after edge k, and the pop happens at edge k+1. tx falls low and busy rises after edge k+1.
- Frame length is exactly 10*CLK_DIV enabled cycles.
- Baud counter: counts 0..CLK_DIV-1, width $clog2(CLK_DIV). The bit advances when the count equals CLK_DIV-1; the counter wraps to 0.
- FIFO occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- fifo_full and fifo_empty are registered-state derived, with no combinational path from capture.
- tx, busy and the flags are driven from registers (glitch-free pin).
- Reset mid-frame: tx returns to 1 immediately and asynchronously; the frame is abandoned and the FIFO contents are discarded.

Decomposition:
- Shared package count_uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP}
  - FRAME_DATA_BITS=8, TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- One sub-module, snap_fifo: synchronous FIFO with parameterised depth and width.
  - Ports: push, pop, wdata, rdata, full, empty, plus an ena gate.
  - Instantiated once; the FSM and baud logic stay in the top.

Test Plan:
All scenarios use CLK_DIV=4, FIFO_DEPTH=4.
1. Reset released, no capture for 50 cycles -> tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0 throughout.
2. Single capture, data_in=0xA5 -> tx goes low 2 edges after capture for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. busy is high for exactly 40 cycles, and the FIFO is empty after the pop.
3. Captures on 5 consecutive cycles with data_in 0x01..0x05 -> 0x01 is popped immediately and 0x02..0x05 fill the FIFO (fifo_full=1, overflow=0). A 6th capture with 0x06 -> overflow=1, 0x06 never sent. Frames 0x01..0x05 are sent back to back in 200 cycles with no idle gap.
4. ena=0 for 10 cycles during data bit 3 of 0x3C -> tx level and busy hold; the frame completes 10 cycles late with the payload bits intact.
5. rst_n asserted mid-DATA with 2 entries queued -> tx=1 and busy=0 asynchronously. After release: fifo_empty=1, no further frames, overflow=0.
6. FIFO full with overflow=1; capture=1 and clear_ovf=1 in the same cycle with no pop -> overflow stays 1. clear_ovf alone on the next cycle -> overflow=0.
